rst_seq_ctrl: RTL
=================

// Module: rst_seq_ctrl
// PURPOSE
//   Reset sequencer for the SoC clock domain. It sits between the board-level reset
//   synchronizer / PLL and the SoC subsystems, and drives NUM_DOM ordered, active-high
//   reset outputs (for example interconnect, CPU, UART and peripherals). All domains
//   are held in reset until the PLL is stably locked, then released one at a time,
//   lowest index first. Any PLL lock loss, software reset request or watchdog expiry
//   re-runs the sequence, and the cause of the most recent reset is recorded.
// PARAMETERS
//   NUM_DOM   4   number of sequenced reset domains (1..8)
//   HOLD_CYC  16  cycles spent in ASSERT; also the gap before each domain release (>=2)
//   LOCK_CYC  32  consecutive cycles pll_locked_i must be high before release starts (>=1)
//   CNT_W     8   counter width; must satisfy 2**CNT_W > max(HOLD_CYC, LOCK_CYC)
// PORTS
//   clk_i         in   1        SoC clock; all logic is on the rising edge
//   rst_i         in   1        synchronous, active-high reset
//   pll_locked_i  in   1        PLL lock flag, already synchronized to clk_i
//   sw_rst_req_i  in   1        one-cycle software reset request pulse
//   wdt_expire_i  in   1        one-cycle watchdog expiry pulse
//   dom_rst_o     out  NUM_DOM  per-domain reset, active high; bit 0 is released first
//   seq_done_o    out  1        high while in RUN with all domains released
//   busy_o        out  1        high whenever the state is not RUN
//   rst_cause_o   out  4        one-hot cause of the last reset: [0]=POR [1]=PLL loss [2]=SW [3]=WDT
// BEHAVIOUR
// - All outputs are registered.
//   - Under rst_i: state=ASSERT, cnt=0, idx=0, dom_rst_o=all 1, seq_done_o=0,
//     busy_o=1, rst_cause_o=4'b0001.
// - ASSERT: all domains are held in reset and cnt counts from 0.
//   - When cnt==HOLD_CYC-1: go to WAIT_LOCK and clear cnt.
//   - pll_locked_i is ignored in this state.
// - WAIT_LOCK: cnt increments while pll_locked_i=1 and is cleared whenever pll_locked_i=0.
//   - When cnt==LOCK_CYC-1 with pll_locked_i=1: go to RELEASE with idx=0 and cnt=0.
// - RELEASE: cnt counts from 0.
//   - When cnt==HOLD_CYC-1: clear dom_rst_o[idx], increment idx and clear cnt.
//   - When idx==NUM_DOM-1 is released, go to RUN in the same cycle.
//   - Let cycle T be the first cycle in RELEASE. Domain k is seen deasserted at
//     T+(k+1)*HOLD_CYC. seq_done_o=1 and busy_o=0 are seen in the same cycle as the
//     last domain's deassertion.
// - RUN: dom_rst_o=0, seq_done_o=1, busy_o=0. Restart events are evaluated by priority:
//   - pll_locked_i=0: restart with cause PLL, which wins over every other event.
//   - else wdt_expire_i=1: restart with cause WDT.
//   - else sw_rst_req_i=1: restart with cause SW.
// - Restart from RUN: on the next edge, dom_rst_o=all 1, seq_done_o=0, busy_o=1,
//   state=ASSERT, cnt=0, idx=0, and rst_cause_o is overwritten with the new one-hot cause.
// - pll_locked_i=0 during RELEASE: re-assert all domains on the next edge, go to
//   ASSERT and set cause=PLL.
// - sw_rst_req_i and wdt_expire_i are ignored outside RUN: the sequence is already
//   running and the pulse is dropped, not queued.
// - rst_i wins over every event in every state and sets cause=POR.
// - rst_cause_o holds its value until the next restart and is always one-hot.
// - Once released, a domain never re-asserts individually: re-assertion is always all
//   domains at once.
// - Outputs never glitch: dom_rst_o bits change only on clk_i edges, and at most one
//   bit falls per cycle.
// TESTING
// - POR: HOLD_CYC=16, LOCK_CYC=32, NUM_DOM=4, pll_locked_i=1 held, rst_i for 3 cycles
//   -> dom_rst_o steps 1111 -> 1110 -> 1100 -> 1000 -> 0000, one step every 16 cycles;
//   seq_done_o=1 with the 0000 step; rst_cause_o=0001.
// - Lock wobble: pll_locked_i drops for 1 cycle at WAIT_LOCK cnt=20 -> the lock count
//   restarts, and the first release comes 32+16 cycles after lock returns.
// - SW reset: in RUN, pulse sw_rst_req_i -> next edge dom_rst_o=1111 and
//   rst_cause_o=0100; the full sequence then repeats.
// - Priority: in RUN, assert wdt_expire_i, sw_rst_req_i and pll_locked_i=0 in the same
//   cycle -> rst_cause_o=0010; with pll_locked_i=1 in that cycle -> rst_cause_o=1000.
// - Mid-sequence lock loss: pll_locked_i=0 after 2 domains are released -> next edge
//   dom_rst_o=1111, cause=0010, state=ASSERT.
// - Ignored request: pulse sw_rst_req_i during RELEASE -> no change to timing or cause.

Source files
------------

// File: rtl/rst_seq_ctrl.sv
// rst_seq_ctrl: ordered reset sequencer for the SoC clock domain.
// Holds NUM_DOM resets until the PLL is stably locked, then releases them in
// index order, one every HOLD_CYC cycles. Restarts on lock loss, SW or WDT.
//
// Ports:
//   clk_i         SoC clock, rising edge
//   rst_i         synchronous active-high reset (cause = POR)
//   pll_locked_i  PLL lock flag, already synchronous to clk_i
//   sw_rst_req_i  one-cycle software reset request
//   wdt_expire_i  one-cycle watchdog expiry
//   dom_rst_o     per-domain reset, active high, bit 0 released first
//   seq_done_o    high in RUN with all domains released
//   busy_o        high whenever not in RUN
//   rst_cause_o   one-hot last cause: [0]POR [1]PLL [2]SW [3]WDT
module rst_seq_ctrl #(
    parameter int NUM_DOM  = 4,
    parameter int HOLD_CYC = 16,
    parameter int LOCK_CYC = 32,
    parameter int CNT_W    = 8
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               pll_locked_i,
    input  logic               sw_rst_req_i,
    input  logic               wdt_expire_i,
    output logic [NUM_DOM-1:0] dom_rst_o,
    output logic               seq_done_o,
    output logic               busy_o,
    output logic [3:0]         rst_cause_o
);

    localparam int IDX_W = (NUM_DOM > 1) ? $clog2(NUM_DOM) : 1;

    localparam logic [3:0] CAUSE_POR = 4'b0001;
    localparam logic [3:0] CAUSE_PLL = 4'b0010;
    localparam logic [3:0] CAUSE_SW  = 4'b0100;
    localparam logic [3:0] CAUSE_WDT = 4'b1000;

    typedef enum logic [1:0] {
        ST_ASSERT,
        ST_WAIT_LOCK,
        ST_RELEASE,
        ST_RUN
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [IDX_W-1:0] idx;

    logic             restart;
    logic [3:0]       new_cause;
    logic             hold_end;
    logic             lock_end;
    logic             last_dom;

    assign hold_end = (cnt == CNT_W'(HOLD_CYC - 1));
    assign lock_end = (cnt == CNT_W'(LOCK_CYC - 1));
    assign last_dom = (idx == IDX_W'(NUM_DOM - 1));

    // Lock loss outranks WDT, which outranks SW. Only RUN and RELEASE
    // can restart; SW/WDT pulses elsewhere are dropped.
    always_comb begin
        restart   = 1'b0;
        new_cause = rst_cause_o;
        if (state == ST_RUN) begin
            if (!pll_locked_i) begin
                restart   = 1'b1;
                new_cause = CAUSE_PLL;
            end else if (wdt_expire_i) begin
                restart   = 1'b1;
                new_cause = CAUSE_WDT;
            end else if (sw_rst_req_i) begin
                restart   = 1'b1;
                new_cause = CAUSE_SW;
            end
        end else if (state == ST_RELEASE && !pll_locked_i) begin
            restart   = 1'b1;
            new_cause = CAUSE_PLL;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= ST_ASSERT;
            cnt         <= '0;
            idx         <= '0;
            dom_rst_o   <= '1;
            seq_done_o  <= 1'b0;
            busy_o      <= 1'b1;
            rst_cause_o <= CAUSE_POR;
        end else if (restart) begin
            state       <= ST_ASSERT;
            cnt         <= '0;
            idx         <= '0;
            dom_rst_o   <= '1;
            seq_done_o  <= 1'b0;
            busy_o      <= 1'b1;
            rst_cause_o <= new_cause;
        end else begin
            unique case (state)
                ST_ASSERT: begin
                    dom_rst_o <= '1;
                    if (hold_end) begin
                        state <= ST_WAIT_LOCK;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_WAIT_LOCK: begin
                    if (!pll_locked_i) begin
                        cnt <= '0;
                    end else if (lock_end) begin
                        state <= ST_RELEASE;
                        cnt   <= '0;
                        idx   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_RELEASE: begin
                    if (hold_end) begin
                        // Zero-fill shift drops exactly the lowest
                        // still-asserted bit, so one bit falls per step.
                        dom_rst_o <= dom_rst_o << 1;
                        cnt       <= '0;
                        if (last_dom) begin
                            state      <= ST_RUN;
                            idx        <= '0;
                            seq_done_o <= 1'b1;
                            busy_o     <= 1'b0;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_RUN: begin
                    dom_rst_o  <= '0;
                    seq_done_o <= 1'b1;
                    busy_o     <= 1'b0;
                end
                default: begin
                    state <= ST_ASSERT;
                end
            endcase
        end
    end

endmodule
